stat_update_ctrl: RTL and testbench

- Front-end controller for the max/min/avg datapath.
- Consumes an 8-bit sample stream over a valid/ready handshake and tracks running max, min, sum and count.
- Drives value/load pairs into the downstream Max, Min and Avg holding registers.
- At end of block, computes the average with a sequential restoring divider and pulses the average load.

---
 rtl/stat_pkg.sv | 16 +
 rtl/seq_divider.sv | 63 ++++++
 rtl/stat_update_ctrl.sv | 124 ++++++++++++
 tb/tb_stat_update_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stat_pkg.sv
// Shared types and default sizes for the max/min/avg statistics front end.
package stat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } stat_state_t;

  localparam int STAT_DATA_W    = 8;
  localparam int STAT_SUM_W     = 16;
  localparam int STAT_MAX_COUNT = 255;
  localparam int STAT_CNT_W     = $clog2(STAT_MAX_COUNT + 1);

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, fixed SUM_W-cycle latency.
module seq_divider
  import stat_pkg::*;
#(
  parameter int DATA_W = STAT_DATA_W,
  parameter int SUM_W  = STAT_SUM_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_start,
  input  logic [SUM_W-1:0]  i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quot
);

  localparam int STEP_W = $clog2(SUM_W + 1);

  logic              r_busy;
  logic [STEP_W-1:0] r_step;
  logic [SUM_W-1:0]  r_dvd;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;

  logic [DATA_W:0]   w_sh;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [SUM_W-1:0]  w_q_nxt;

  // Dividend register doubles as the quotient shift register.
  assign w_sh      = {r_rem, r_dvd[SUM_W-1]};
  assign w_ge      = (w_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? DATA_W'(w_sh - {1'b0, r_dvs})
                          : w_sh[DATA_W-1:0];
  assign w_q_nxt   = {r_dvd[SUM_W-2:0], w_ge};

  // done and quotient are presented during the final step.
  assign o_done = r_busy && (r_step == STEP_W'(1));
  assign o_quot = (r_dvs == '0) ? '0 : w_q_nxt[DATA_W-1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_busy <= 1'b0;
      r_step <= '0;
      r_dvd  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_step <= STEP_W'(SUM_W);
      r_dvd  <= i_dividend;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
    end else if (r_busy) begin
      r_dvd  <= w_q_nxt;
      r_rem  <= w_rem_nxt;
      r_step <= r_step - STEP_W'(1);
      if (r_step == STEP_W'(1))
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stat_update_ctrl.sv
// Sample-stream controller: running max/min, sum/count, and end-of-block average.
module stat_update_ctrl
  import stat_pkg::*;
#(
  parameter int DATA_W    = STAT_DATA_W,
  parameter int SUM_W     = STAT_SUM_W,
  parameter int MAX_COUNT = STAT_MAX_COUNT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              sample_last,
  output logic              sample_ready,
  output logic [DATA_W-1:0] max_val,
  output logic              max_load,
  output logic [DATA_W-1:0] min_val,
  output logic              min_load,
  output logic [DATA_W-1:0] avg_val,
  output logic              avg_load,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(MAX_COUNT + 1);

  stat_state_t       r_state;
  logic [SUM_W-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_first;

  logic              w_acc;
  logic              w_end;
  logic [SUM_W-1:0]  w_sum_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_div_start;
  logic              w_div_done;
  logic [DATA_W-1:0] w_quot;

  assign sample_ready = (r_state == ACCUM);
  assign busy         = (r_state == ACCUM) || (r_state == DIVIDE);

  assign w_acc     = sample_valid && sample_ready;
  assign w_sum_nxt = r_sum + SUM_W'(sample_in);
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_end     = sample_last || (w_cnt_nxt == CNT_W'(MAX_COUNT));

  // Divider loads the post-update totals on the terminating accept.
  assign w_div_start = w_acc && w_end;

  seq_divider #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_div (
    .CLK        (CLK),
    .RESET      (RESET),
    .i_start    (w_div_start),
    .i_dividend (w_sum_nxt),
    .i_divisor  (DATA_W'(w_cnt_nxt)),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      max_val  <= '0;
      max_load <= 1'b0;
      min_val  <= '0;
      min_load <= 1'b0;
      avg_val  <= '0;
      avg_load <= 1'b0;
      done     <= 1'b0;
    end else begin
      max_load <= 1'b0;
      min_load <= 1'b0;
      avg_load <= 1'b0;
      done     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ACCUM;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b1;
          end
        end
        ACCUM: begin
          if (w_acc) begin
            r_sum   <= w_sum_nxt;
            r_cnt   <= w_cnt_nxt;
            r_first <= 1'b0;
            // max_val/min_val are the running extremes.
            if (r_first || sample_in > max_val) begin
              max_val  <= sample_in;
              max_load <= 1'b1;
            end
            if (r_first || sample_in < min_val) begin
              min_val  <= sample_in;
              min_load <= 1'b1;
            end
            if (w_end)
              r_state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (w_div_done) begin
            r_state  <= DONE;
            avg_val  <= w_quot;
            avg_load <= 1'b1;
            done     <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stat_update_ctrl.sv
// Directed bench for stat_update_ctrl: loads, averages, cap, backpressure, reset.
module tb_stat_update_ctrl;
  import stat_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_last;
  logic       sample_ready;
  logic [7:0] max_val;
  logic       max_load;
  logic [7:0] min_val;
  logic       min_load;
  logic [7:0] avg_val;
  logic       avg_load;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  stat_update_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_last  (sample_last),
    .sample_ready (sample_ready),
    .max_val      (max_val),
    .max_load     (max_load),
    .min_val      (min_val),
    .min_load     (min_load),
    .avg_val      (avg_val),
    .avg_load     (avg_load),
    .busy         (busy),
    .done         (done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("accum_ready", sample_ready, 1);
    chk("accum_busy", busy, 1);
  endtask

  task automatic send(input logic [7:0] x, input logic l,
                      input logic eml, input logic enl,
                      input logic [7:0] emx, input logic [7:0] emn);
    chk("ready", sample_ready, 1);
    sample_in    = x;
    sample_valid = 1'b1;
    sample_last  = l;
    @(negedge CLK);
    sample_valid = 1'b0;
    sample_last  = 1'b0;
    chk("max_load", max_load, eml);
    chk("min_load", min_load, enl);
    chk("max_val", max_val, emx);
    chk("min_val", min_val, emn);
  endtask

  // Called at the negedge right after the last accept (cycle t+1).
  task automatic wait_avg(input logic [7:0] e);
    int n = 0;
    chk("div_ready", sample_ready, 0);
    while (!avg_load && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("avg_latency", n, 16);
    chk("avg_val", avg_val, e);
    chk("done", done, 1);
    @(negedge CLK);
    chk("done_pulse", done, 0);
    chk("avg_pulse", avg_load, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    sample_last = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    chk("rst_ready", sample_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_max", max_val, 0);
    chk("rst_min", min_val, 0);
    chk("rst_avg", avg_val, 0);
    chk("rst_done", done, 0);

    // Single sample
    go();
    send(8'h2A, 1'b1, 1'b1, 1'b1, 8'h2A, 8'h2A);
    wait_avg(8'h2A);

    // 10,50,30,50,5 -> avg 29
    go();
    send(8'd10, 1'b0, 1'b1, 1'b1, 8'd10, 8'd10);
    send(8'd50, 1'b0, 1'b1, 1'b0, 8'd50, 8'd10);
    send(8'd30, 1'b0, 1'b0, 1'b0, 8'd50, 8'd10);
    send(8'd50, 1'b0, 1'b0, 1'b0, 8'd50, 8'd10);
    send(8'd5,  1'b1, 1'b0, 1'b1, 8'd50, 8'd5);
    wait_avg(8'd29);

    // Truncation, with valid held through DIVIDE
    go();
    send(8'd1, 1'b0, 1'b1, 1'b1, 8'd1, 8'd1);
    send(8'd2, 1'b1, 1'b1, 1'b0, 8'd2, 8'd1);
    sample_in    = 8'h80;
    sample_valid = 1'b1;
    wait_avg(8'd1);
    sample_valid = 1'b0;

    go();
    send(8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    send(8'hFE, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFE);
    wait_avg(8'hFE);

    // start pulsed mid-block must not clear
    go();
    send(8'd4, 1'b0, 1'b1, 1'b1, 8'd4, 8'd4);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    send(8'd8, 1'b1, 1'b1, 1'b0, 8'd8, 8'd4);
    wait_avg(8'd6);

    // Count cap: 255 samples of 0xFF, no last
    go();
    send(8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    for (int i = 1; i < 255; i++)
      send(8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    wait_avg(8'hFF);

    // Reset during DIVIDE cycle 5
    go();
    send(8'd100, 1'b0, 1'b1, 1'b1, 8'd100, 8'd100);
    send(8'd200, 1'b1, 1'b1, 1'b0, 8'd200, 8'd100);
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", sample_ready, 0);
    chk("mid_rst_max", max_val, 0);
    chk("mid_rst_min", min_val, 0);
    chk("mid_rst_avg", avg_val, 0);
    chk("mid_rst_avgld", avg_load, 0);
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge CLK);
        if (avg_load || done) seen++;
      end
      chk("no_avg_after_rst", seen, 0);
    end
    go();
    send(8'd7, 1'b1, 1'b1, 1'b1, 8'd7, 8'd7);
    wait_avg(8'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
